// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer built around a single 4-bit
// carry-lookahead slice, retiring one nibble per clock, LSB nibble first.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module cla_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       state_dbg
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       slice_sum;
    logic             slice_co;
    logic             last;

    // Handshake: start is accepted on a rising edge only while ready (IDLE) is
    // high; done pulses for one cycle when result/co/ovf are valid; start is
    // ignored while busy or done.
    cla4 u_cla4 (
        .a  (op_a[4*idx +: 4]),
        .b  (op_b[4*idx +: 4]),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    assign last      = (idx == IDX_W'(NSLICE - 1));
    assign ready     = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN: begin
                if (abort)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // An aborted edge still retires its nibble, but co/ovf only move on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_a  <= a;
                op_b  <= op_sub ? ~b : b;
                carry <= op_sub;
                idx   <= '0;
            end else if (state == RUN) begin
                result[4*idx +: 4] <= slice_sum;
                carry              <= slice_co;
                idx                <= idx + 1'b1;
                if (last && !abort) begin
                    co  <= slice_co;
                    ovf <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_sum[3] != op_a[WIDTH-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl at WIDTH=16: vector table plus
// hand-written sequences for ignored starts, abort and mid-run reset.

module tb_cla_seq_adder_ctrl;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op_sub;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        co;
    logic        ovf;
    logic [1:0]  state_dbg;

    typedef struct {
        logic        op_sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_result;
        logic        exp_co;
        logic        exp_ovf;
        logic        with_abort;
    } vec_t;

    vec_t vecs[9];
    int   n_vec;
    int   n_err;

    cla_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op_sub    (op_sub),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .co        (co),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        logic seen;
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        start  = 1'b1;
        op_sub = v.op_sub;
        a      = v.a;
        b      = v.b;
        abort  = v.with_abort;
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        a      = 16'($urandom);
        b      = 16'($urandom);
        op_sub = 1'($urandom_range(0, 1));
        check("busy_after_start", {30'd0, busy, ready}, 32'b10);
        cyc  = 1;
        seen = done;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        check("latency", seen ? 32'(cyc) : 32'hdead, 32'd5);
        check("result", 32'(result), 32'(v.exp_result));
        check("co", 32'(co), 32'(v.exp_co));
        check("ovf", 32'(ovf), 32'(v.exp_ovf));
        @(negedge clk);
        check("idle_after_done", {30'd0, ready, done}, 32'b10);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        abort   = 1'b0;
        a       = '0;
        b       = '0;

        //           sub   a         b         result    co    ovf   abort
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0};

        // Reset values
        #12;
        check("reset_flags", {27'd0, ready, busy, done, co, ovf}, 32'b10000);
        check("reset_result", 32'(result), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // start held every cycle through RUN and DONE: only the first op runs
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h0100; b = 16'h0200;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ready) break;
            if (done) check("hold_start_result", 32'(result), 32'h0300);
            a      = 16'($urandom);
            b      = 16'($urandom);
            op_sub = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        check("hold_start_ready", 32'(ready), 32'd1);
        repeat (3) @(negedge clk);
        check("no_queued_op", {15'd0, ready, result}, {15'd0, 1'b1, 16'h0300});

        // abort in the 2nd RUN cycle of 0x1111+0x2222
        start = 1'b1; op_sub = 1'b0; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {29'd0, ready, busy, done}, 32'b100);
        check("abort_result", 32'(result), 32'h0333);
        check("abort_co_ovf", {30'd0, co, ovf}, 32'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(vecs[1]);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_flags", {27'd0, ready, busy, done, co, ovf}, 32'b10000);
        check("midreset_result", 32'(result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) check("midreset_no_done", 32'(done), 32'd0);
        end
        run_op(vecs[0]);
        run_op(vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
